// File: rtl/axis_matvec_loader.sv
// axis_matvec_loader: gathers R weight rows from the K stream and one vector
// from the X stream, then presents them as a single {k, x} beat. Optional: WEIGHT_REUSE_EN.
`default_nettype none

module axis_matvec_loader #(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_k_valid,
  output logic                         s_k_ready,
  input  logic [C*W_K-1:0]             s_k_data,
  input  logic                         s_x_valid,
  output logic                         s_x_ready,
  input  logic [C*W_X-1:0]             s_x_data,
`ifdef WEIGHT_REUSE_EN
  input  logic                         k_reuse,
`endif
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [R*C*W_K+C*W_X-1:0]     m_data
);

  localparam int                 c_CNT_W    = $clog2(R + 1);
  localparam int                 c_ROW_W    = C * W_K;
  localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(R - 1);

  logic [c_CNT_W-1:0] r_row_cnt;
  logic               r_k_full;
  logic               r_x_full;
  logic [c_ROW_W-1:0] r_rows [R];
  logic [C*W_X-1:0]   r_x;

  logic               w_k_hs;
  logic               w_x_hs;
  logic               w_m_hs;
  logic               w_reuse;
  logic [R*c_ROW_W-1:0] w_k_flat;

  // All outputs are decoded from state flops only; nothing from the inputs leaks through.
  assign s_k_ready = ~r_k_full;
  assign s_x_ready = ~r_x_full;
  assign m_valid   = r_k_full & r_x_full;

  assign w_k_hs = s_k_valid & ~r_k_full;
  assign w_x_hs = s_x_valid & ~r_x_full;
  assign w_m_hs = r_k_full & r_x_full & m_ready;

`ifdef WEIGHT_REUSE_EN
  assign w_reuse = k_reuse;
`else
  assign w_reuse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row_cnt <= '0;
      r_k_full  <= 1'b0;
      r_x_full  <= 1'b0;
    end else if (w_m_hs) begin
      // With reuse the matrix stays loaded and row_cnt remains at R.
      r_x_full <= 1'b0;
      if (!w_reuse) begin
        r_k_full  <= 1'b0;
        r_row_cnt <= '0;
      end
    end else begin
      if (w_k_hs) begin
        r_row_cnt <= r_row_cnt + c_CNT_W'(1);
        if (r_row_cnt == c_LAST_ROW) begin
          r_k_full <= 1'b1;
        end
      end
      if (w_x_hs) begin
        r_x_full <= 1'b1;
      end
    end
  end

  generate
    for (genvar r = 0; r < R; r++) begin : g_rows
      always_ff @(posedge clk) begin
        if (w_k_hs && (r_row_cnt == c_CNT_W'(r))) begin
          r_rows[r] <= s_k_data;
        end
      end
      assign w_k_flat[r*c_ROW_W +: c_ROW_W] = r_rows[r];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_x_hs) begin
      r_x <= s_x_data;
    end
  end

  assign m_data = {w_k_flat, r_x};

endmodule

`default_nettype wire

// File: tb/tb_axis_matvec_loader.sv
// tb_axis_matvec_loader: directed and randomized checks of the loader against a queue-based frame model.
`default_nettype none

module tb_axis_matvec_loader;

  localparam int R   = 2;
  localparam int C   = 2;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int KW  = C * W_K;
  localparam int XW  = C * W_X;
  localparam int MW  = R * KW + XW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_k_valid = 1'b0;
  logic          s_k_ready;
  logic [KW-1:0] s_k_data = '0;
  logic          s_x_valid = 1'b0;
  logic          s_x_ready;
  logic [XW-1:0] s_x_data = '0;
  logic          k_reuse = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [MW-1:0] m_data;

  int errors = 0;
  int checks = 0;

  // Reference model: rows accepted so far, and the latched vector if any.
  logic [KW-1:0] mdl_rows[$];
  logic          mdl_x_have = 1'b0;
  logic [XW-1:0] mdl_x = '0;

  always #5 clk = ~clk;

  axis_matvec_loader #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_k_valid (s_k_valid),
    .s_k_ready (s_k_ready),
    .s_k_data  (s_k_data),
    .s_x_valid (s_x_valid),
    .s_x_ready (s_x_ready),
    .s_x_data  (s_x_data),
`ifdef WEIGHT_REUSE_EN
    .k_reuse   (k_reuse),
`endif
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] mdl_beat();
    logic [63:0] e;
    e = 64'(mdl_x);
    for (int r = 0; r < R; r++) e |= 64'(mdl_rows[r]) << (XW + r * KW);
    return e;
  endfunction

  task automatic cycle(input logic kv, input logic [KW-1:0] kd, input logic xv,
                       input logic [XW-1:0] xd, input logic mr, input logic reuse);
    logic ek, ex, ev, eff_reuse;
    s_k_valid = kv; s_k_data = kd;
    s_x_valid = xv; s_x_data = xd;
    m_ready = mr;   k_reuse = reuse;
`ifdef WEIGHT_REUSE_EN
    eff_reuse = reuse;
`else
    eff_reuse = 1'b0;
`endif
    @(negedge clk);
    ek = (mdl_rows.size() < R);
    ex = !mdl_x_have;
    ev = !ek && !ex;
    check("k_ready", 64'(s_k_ready), 64'(ek));
    check("x_ready", 64'(s_x_ready), 64'(ex));
    check("m_valid", 64'(m_valid), 64'(ev));
    if (ev) check("m_data", 64'(m_data), mdl_beat());
    @(posedge clk);
    if (ev && mr) begin
      mdl_x_have = 1'b0;
      if (!eff_reuse) mdl_rows.delete();
    end
    if (kv && ek) mdl_rows.push_back(kd);
    if (xv && ex) begin mdl_x_have = 1'b1; mdl_x = xd; end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_k_valid = 1'b0; s_x_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_k_ready", 64'(s_k_ready), 64'd1);
    check("rst_x_ready", 64'(s_x_ready), 64'd1);
    mdl_rows.delete();
    mdl_x_have = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_m_valid", 64'(m_valid), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Basic frame
    cycle(1'b1, 16'h0201, 1'b1, 16'h0605, 1'b1, 1'b0);
    cycle(1'b1, 16'h0403, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("basic_valid", 64'(m_valid), 64'd1);
    check("basic_data", 64'(m_data), 64'h0403_0201_0605);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // X first; a second X offered while full must be ignored
    cycle(1'b0, 16'h0, 1'b1, 16'h1111, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 16'h2222, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 16'h2222, 1'b1, 1'b0);
    cycle(1'b1, 16'haaaa, 1'b1, 16'h3333, 1'b0, 1'b0);
    cycle(1'b1, 16'hbbbb, 1'b1, 16'h3333, 1'b0, 1'b0);
    check("xfirst_x_field", 64'(m_data[XW-1:0]), 64'h1111);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure: frame completes, m_ready low for 5 cycles, offered beats refused
    cycle(1'b1, 16'h1357, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2468, 1'b1, 16'h9abc, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'hffff, 1'b1, 16'heeee, 1'b0, 1'b0);
    cycle(1'b1, 16'hffff, 1'b1, 16'heeee, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Back-to-back frames with continuous valids
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 16'($urandom_range(0, 65535)), 1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Reset mid-frame discards the partial row
    cycle(1'b1, 16'hdead, 1'b0, 16'h0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0a0b, 1'b1, 16'h0c0d, 1'b1, 1'b0);
    cycle(1'b1, 16'h0e0f, 1'b0, 16'h0, 1'b1, 1'b0);
    check("rst_frame_data", 64'(m_data), 64'h0e0f_0a0b_0c0d);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

`ifdef WEIGHT_REUSE_EN
    cycle(1'b1, 16'h0201, 1'b1, 16'h0605, 1'b1, 1'b0);
    cycle(1'b1, 16'h0403, 1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle(1'b1, 16'h5555, 1'b1, 16'h0807, 1'b0, 1'b0);
    check("reuse_data", 64'(m_data), 64'h0403_0201_0807);
    check("reuse_k_ready", 64'(s_k_ready), 64'd0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_matvec_loader.md
Name: axis_matvec_loader

Overview:
- AXI-stream loader on the input side of the matrix-vector multiplier.
- Collects R matrix rows from a narrow K stream (one row of C weights per beat) and one C-element vector from an X stream.
- Presents the result as one wide beat whose layout is {k, x}, matching the multiplier's s_data.
- Sits between the weight/activation DMA streams and the multiplier's slave port.

Parameters:
- R, 8, matrix rows (number of K beats per frame); R >= 1.
- C, 8, matrix columns / vector length; C >= 1.
- W_X, 8, bits per vector element.
- W_K, 8, bits per matrix weight.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- s_k_valid  input  1  K-stream beat valid.
- s_k_ready  output  1  K-stream ready.
- s_k_data  input  C*W_K  one matrix row; element c at bits [c*W_K +: W_K].
- s_x_valid  input  1  X-stream beat valid.
- s_x_ready  output  1  X-stream ready.
- s_x_data  input  C*W_X  full vector; element c at bits [c*W_X +: W_X].
- m_valid  output  1  wide beat valid.
- m_ready  input  1  downstream ready.
- m_data  output  R*C*W_K+C*W_X  {k, x}; row r at k bits [r*C*W_K +: C*W_K]; x in the low C*W_X bits.

Behaviour:
- Reset is asynchronous on negedge rstn and clears all control state:
  - row_cnt = 0, k_full = 0, x_full = 0.
  - s_k_ready = 1, s_x_ready = 1 (one cycle after rstn deasserts is also acceptable, but 1 is the decided value).
  - m_valid = 0.
  - Data registers need no reset. m_data is don't-care while m_valid = 0.
- K collection:
  - row_cnt is $clog2(R+1) bits.
  - s_k_ready = !k_full.
  - On a K handshake, s_k_data is written to row slot row_cnt and row_cnt increments.
  - When row_cnt reaches R, k_full = 1.
  - Rows arrive in order: row 0 first.
- X collection:
  - s_x_ready = !x_full.
  - On an X handshake, s_x_data is latched and x_full = 1.
- The K and X streams are independent. Either may complete first, and both may handshake in the same cycle.
- m_valid = k_full & x_full, driven from registers. There is no combinational path from any input to any output.
- Latency: m_valid rises one cycle after the completing handshake (the last K row or the X beat, whichever is later).
- Output handshake (m_valid & m_ready):
  - k_full, x_full and row_cnt clear on the same clock edge.
  - s_k_ready and s_x_ready return to 1 in the next cycle.
  - Sustained throughput is one frame per R+1 cycles: R K beats, plus one cycle for the output handshake, with the X beat overlapped.
- While m_valid = 1 and m_ready = 0:
  - m_data is held stable.
  - Both ready outputs are 0, so no beats are accepted.
- AXI rules:
  - m_valid must not deassert before the handshake.
  - m_data must not change while m_valid = 1.
  - Input valid signals are not required to remain asserted; a beat is accepted only when valid & ready.
- A reset mid-frame discards partial rows. The next K beat after reset is row 0.

Optional Feature:
- Macro: WEIGHT_REUSE_EN.
- Defined:
  - Adds input port k_reuse (1 bit), sampled only on the output handshake.
  - If k_reuse = 1 at the handshake, k_full and the matrix registers are kept and row_cnt stays at R.
  - Only x_full clears, so the next frame needs only one X beat. s_k_ready stays 0.
  - If k_reuse = 0, behaviour is as without the macro.
- Not defined: the port is absent and every frame reloads R rows.

Test Plan:
- Basic frame (R=2, C=2, W=8):
  - Stimulus: K rows 0x0201, 0x0403; X 0x0605; m_ready = 1.
  - Response: m_valid one cycle after the last beat; m_data = 0x0403_0201_0605.
  - s_k_ready and s_x_ready are 1 again the cycle after the handshake.
- X first:
  - Stimulus: X beat at cycle 0, then K rows at cycles 3 and 4.
  - Response: s_x_ready = 0 from cycle 1; m_valid at cycle 5.
  - A second X beat offered during cycles 1–4 is not accepted.
- Backpressure:
  - Stimulus: frame completes while m_ready = 0 for 5 cycles.
  - Response: m_valid held at 1; m_data stable; both ready outputs 0.
  - Exactly one output handshake occurs when m_ready rises.
- Back-to-back frames with continuous valids:
  - Response: two distinct correct beats.
  - Period is R+1 cycles, with no row from frame 2 landing in frame 1.
- Reset mid-frame:
  - Stimulus: assert rstn low after 1 of 2 K rows, then send a full new frame.
  - Response: m_valid = 0 during reset; output contains only the new rows.
- With WEIGHT_REUSE_EN:
  - Stimulus: first frame loads K; handshake with k_reuse = 1; send X 0x0807 only.
  - Response: second beat = 0x0403_0201_0807; s_k_ready stays 0 throughout.
